// File: rtl/reg_file_pkg.sv
// Shared constants and types for the integer register file.
package reg_file_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;
    localparam int REG_S2   = 18;

    typedef logic [$clog2(DEF_NREGS)-1:0] reg_idx_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level inputs.
// Latency: two rising edges. No backpressure.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file: write-first reads, busy scoreboard, input-mapped trigger.
// Reads 0-cycle; writes and busy updates land on the next edge. No backpressure; stall flags RAW hazards.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int TRIG_REG = REG_S2,
    parameter int A0_REG   = REG_A0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                stall,
    output logic [NREGS-1:0]    busy,
    output logic [XLEN-1:0]     a0,
    input  logic                trigger
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [0:0]       trig_sync;
    logic [NRD-1:0]   stall_vec;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Register 0 and the trigger register are never written nor tracked as busy.
    function automatic logic writable(input logic [AW-1:0] a);
        return in_range(a) && (int'(a) != REG_ZERO) && (int'(a) != TRIG_REG);
    endfunction

    sync_2ff #(.W(1)) u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger),
        .q     (trig_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (wr_en && writable(wr_addr)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Clear first, then set: a fresh issue to the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en && in_range(wr_addr)) busy_d[wr_addr] = 1'b0;
        if (iss_en && writable(iss_addr)) busy_d[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic [XLEN-1:0] rd_word;

        assign ra  = rd_addr[g*AW +: AW];
        assign hit = rst_n && wr_en && writable(wr_addr) && (wr_addr == ra);

        always_comb begin
            if (!in_range(ra) || int'(ra) == REG_ZERO) rd_word = '0;
            else if (int'(ra) == TRIG_REG)             rd_word = XLEN'(trig_sync);
            else if (hit)                              rd_word = wr_data;
            else                                       rd_word = regs_q[ra];
        end

        assign rd_data[g*XLEN +: XLEN] = rd_word;
        assign stall_vec[g] = in_range(ra) && busy_q[ra] && !(wr_en && (wr_addr == ra));
    end

    assign stall = |stall_vec;
    assign busy  = busy_q;
    assign a0    = regs_q[A0_REG];

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised scoreboard bench for reg_file_sb with four read ports.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 4;
    localparam int AW = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [XLEN-1:0]    wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic               stall;
    logic [NREGS-1:0]   busy;
    logic [XLEN-1:0]    a0;
    logic               trigger;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .TRIG_REG(18), .A0_REG(10)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .stall(stall), .busy(busy),
        .a0(a0), .trigger(trigger)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*XLEN-1:0] rd;
        logic                stall;
        logic [NREGS-1:0]    busy;
        logic [XLEN-1:0]     a0;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: architectural values, in-flight set, trigger history.
    logic [XLEN-1:0] mem [NREGS];
    bit              inflight [NREGS];
    bit              trig_d1, trig_d2;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mem[r] = '0;
            inflight[r] = 1'b0;
        end
        trig_d1 = 1'b0;
        trig_d2 = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] model_read(input int a, input bit we, input int wa,
                                                   input logic [XLEN-1:0] wd);
        if (a == 0) return '0;
        if (a == 18) return {31'b0, trig_d2};
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    // Drive one cycle of inputs, queue what the outputs must show, advance the model.
    task automatic cycle(input bit we, input int wa, input logic [XLEN-1:0] wd,
                         input bit ie, input int ia,
                         input int r0, input int r1, input int r2, input int r3, input bit trg);
        int   ra [NRD];
        exp_t e;
        @(posedge clk);
        #1;
        ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        iss_en = ie; iss_addr = AW'(ia); trigger = trg;
        e.stall = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            rd_addr[p*AW +: AW] = AW'(ra[p]);
            e.rd[p*XLEN +: XLEN] = model_read(ra[p], we, wa, wd);
            if (inflight[ra[p]] && !(we && wa == ra[p])) e.stall = 1'b1;
        end
        for (int r = 0; r < NREGS; r++) e.busy[r] = inflight[r];
        e.a0 = mem[10];
        exp_q.push_back(e);
        if (we && wa != 0 && wa != 18) mem[wa] = wd;
        if (we) inflight[wa] = 1'b0;
        if (ie && ia != 0 && ia != 18) inflight[ia] = 1'b1;
        trig_d2 = trig_d1;
        trig_d1 = trg;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NRD; p++)
                    chk($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], e.rd[p*XLEN +: XLEN]);
                chk("stall", {31'b0, stall}, {31'b0, e.stall});
                chk("busy", busy, e.busy);
                chk("a0", a0, e.a0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        for (int p = 0; p < NRD; p++)
            chk($sformatf("%s rd_data[%0d]", tag, p), rd_data[p*XLEN +: XLEN], '0);
        chk({tag, " a0"}, a0, '0);
        chk({tag, " busy"}, busy, '0);
        chk({tag, " stall"}, {31'b0, stall}, '0);
    endtask

    initial begin : stim
        rst_n = 1'b0;
        rd_addr = {AW'(3), AW'(18), AW'(10), AW'(5)};
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; trigger = 1'b0;
        model_reset();
        #3;
        chk_reset_outputs("reset");
        #9 rst_n = 1'b1;

        // Bypass into a0's register, then observe a0 after the edge.
        cycle(1, 10, 32'hDEADBEEF, 0, 0, 10, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 10, 0, 0, 0, 0);
        // Writes and issues to x0 / x18 are dropped.
        cycle(1, 0, 32'h1234, 1, 0, 0, 18, 0, 0, 0);
        cycle(1, 18, 32'h5678, 1, 18, 0, 18, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 18, 0, 0, 0);
        // Trigger rises between edges; two edges to reach x18.
        cycle(0, 0, 0, 0, 0, 18, 18, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 18, 18, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 18, 18, 0, 0, 1);
        // RAW hazard on x5 resolved by writeback bypass.
        cycle(0, 0, 0, 1, 5, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 5, 0, 0, 1);
        cycle(1, 5, 32'h7, 0, 0, 0, 5, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 5, 0, 0, 1);
        // Issue and writeback on the same register: busy stays set.
        cycle(1, 6, 32'hA5A5_0006, 1, 6, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 6, 0, 0, 0, 1);
        // Four distinct ports.
        cycle(1, 3, 32'h3333_0003, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 7, 32'h7777_0007, 0, 0, 3, 10, 7, 18, 1);
        cycle(0, 0, 0, 0, 0, 3, 10, 7, 18, 1);

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 31), $urandom,
                  ($urandom_range(0, 9) < 4), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31),
                  ($urandom_range(0, 15) == 0) ? ~trigger : trigger);
        end

        // Asynchronous reset between edges with a write still asserted.
        @(negedge clk);
        #2;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hFFFF_FFFF;
        rd_addr = {AW'(10), AW'(18), AW'(6), AW'(5)};
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        wr_en = 1'b0; trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 10, 32'h0BAD_F00D, 1, 12, 10, 12, 18, 6, 0);
        cycle(0, 0, 0, 0, 0, 10, 12, 18, 6, 0);
        cycle(0, 0, 0, 0, 0, 10, 12, 18, 6, 0);

        @(negedge clk);
        #1;
        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with multiple read ports, write-to-read bypass, a per-register busy scoreboard and a synchronised read-only input-mapped register. Sits in the decode stage of the pipelined RISC-V core. Serves operand reads and the writeback-stage write. The scoreboard tracks in-flight destinations so decode can stall on RAW hazards the bypass cannot resolve.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers; AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- TRIG_REG, 18, index of the read-only input-mapped register
- A0_REG, 10, index exported on a0
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- wr_en  in  1  writeback write enable
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- iss_en  in  1  instruction issued with a destination; mark it busy
- iss_addr  in  AW  destination being issued
- stall  out  1  some read port references a busy register not being written this cycle
- busy  out  NREGS  scoreboard vector
- a0  out  XLEN  architectural value of register A0_REG
- trigger  in  1  asynchronous external input, mapped to TRIG_REG

## Operation
- Reset (rst_n low, asynchronous): all registers 0, busy all 0, trigger synchroniser flops 0. Outputs during reset: rd_data 0, a0 0, busy 0, stall 0.
- Register 0: reads return 0. Writes are ignored. Never marked busy. iss_en to 0 is ignored.
- TRIG_REG: reads return the synchronised trigger bit, zero-extended to XLEN. Writes and issues to it are ignored. Never busy.
- Write: when wr_en is high and wr_addr is neither 0 nor TRIG_REG, wr_data is stored at the rising edge.
- Read is combinational and write-first. If wr_en is high and wr_addr equals rd_addr[i] (excluding 0 and TRIG_REG), rd_data[i] = wr_data in the same cycle. Otherwise rd_data[i] returns the stored value.
- Scoreboard update each edge:
  - busy[wr_addr] cleared when wr_en is high.
  - busy[iss_addr] set when iss_en is high.
  - Same address set and cleared in the same cycle: set wins, because a new producer has been issued.
- stall = OR over i of (busy[rd_addr[i]] AND NOT (wr_en AND wr_addr == rd_addr[i])). stall is combinational.
- a0 = stored value of A0_REG with no bypass. It reflects a write one cycle after the edge.
- Addresses at or above NREGS, when NREGS is not a power of two: reads return 0, writes and issues are ignored.

## Timing
- Read latency is 0 cycles (combinational). Write is visible in storage and on a0 after 1 edge.
- The bypass makes a writeback value visible on rd_data in the same cycle.
- Busy set or clear takes effect after 1 edge. stall responds combinationally to rd_addr, wr_en and wr_addr.
- Trigger latency: 2 rising edges from the input change to the read value (2-flop synchroniser). Pulses shorter than one period may be missed.
- Reset asserted mid-operation clears state immediately, regardless of clk. The first write is accepted on the first rising edge after rst_n rises.

## Structure
- Package reg_file_pkg holds:
  - default XLEN.
  - ABI index constants: REG_ZERO = 0, REG_A0 = 10, REG_S2 = 18.
  - a typedef for register index (logic [AW-1:0]) at the default NREGS.
- Sub-module sync_2ff (width parameter, asynchronous active-low reset) is used for trigger.
- Storage is a flop array with asynchronous reset, not inferred RAM.

## Test plan
- Reset: drive writes, then pulse rst_n low between edges -> all reads 0, a0 = 0, busy = 0, stall = 0 immediately.
- Write x10 = 0xDEADBEEF with rd_addr[0] = 10 in the same cycle -> rd_data[0] = 0xDEADBEEF via bypass, a0 = 0 that cycle and 0xDEADBEEF after the edge.
- Write x0 = 0x1234 and x18 = 0x5678 -> reads of 0 and 18 return 0 with trigger low. busy[0] and busy[18] stay 0 after issues to them.
- Raise trigger between edges -> x18 reads 0 after the first edge, 0x00000001 after the second edge.
- Issue x5, then read rd_addr[1] = 5 -> stall = 1. Writeback x5 = 7 while reading -> stall = 0 and rd_data[1] = 7 that cycle, busy[5] = 0 after the edge.
- Simultaneous iss_en and wr_en to x6 -> busy[6] = 1 after the edge and x6 holds wr_data. With NRD = 4, all ports read distinct registers correctly.
